// File: rtl/agc_dsky_pkg.sv
// Shared constants, relay digit codes and types for the DSKY relay latch.
package agc_dsky_pkg;

   localparam int NROWS = 12;
   localparam int ROWW  = 11;
   localparam int ADRW  = 4;
   localparam int CODEW = 5;

   localparam logic [CODEW-1:0] RC_0 = 5'b10101;
   localparam logic [CODEW-1:0] RC_1 = 5'b00011;
   localparam logic [CODEW-1:0] RC_2 = 5'b11001;
   localparam logic [CODEW-1:0] RC_3 = 5'b11011;
   localparam logic [CODEW-1:0] RC_4 = 5'b01111;
   localparam logic [CODEW-1:0] RC_5 = 5'b11110;
   localparam logic [CODEW-1:0] RC_6 = 5'b11100;
   localparam logic [CODEW-1:0] RC_7 = 5'b10011;
   localparam logic [CODEW-1:0] RC_8 = 5'b11101;
   localparam logic [CODEW-1:0] RC_9 = 5'b11111;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   typedef struct packed {
      logic [ADRW-1:0] adr;
      logic [ROWW-1:0] word;
   } pend_t;

   // Rows are numbered 1..NROWS; row k sits at ROWQ[11k-1 : 11k-11].
   function automatic int rowbase(input int k);
      return ROWW * (k - 1);
   endfunction

   function automatic logic adr_ok(input logic [ADRW-1:0] a);
      return (a != '0) && (a <= ADRW'(NROWS));
   endfunction

endpackage

// File: rtl/dsky_relay_decode.sv
// Relay code to digit decoder: 00000 is blank, unknown nonzero codes give F.
module dsky_relay_decode
   import agc_dsky_pkg::*;
(
   input  logic [CODEW-1:0] code,
   output logic             blk,
   output logic [3:0]       digit
);

   always_comb begin
      blk   = (code == '0);
      digit = 4'hF;
      case (code)
         5'b00000: digit = 4'h0;
         RC_0:     digit = 4'd0;
         RC_1:     digit = 4'd1;
         RC_2:     digit = 4'd2;
         RC_3:     digit = 4'd3;
         RC_4:     digit = 4'd4;
         RC_5:     digit = 4'd5;
         RC_6:     digit = 4'd6;
         RC_7:     digit = 4'd7;
         RC_8:     digit = 4'd8;
         RC_9:     digit = 4'd9;
         default:  digit = 4'hF;
      endcase
   end

endmodule

// File: rtl/dsky_relay_latch.sv
// DSKY latching-relay matrix: captures channel-10 words and commits them to 12 rows.
// Define DSKY_RELAY_DELAY_EN for the relay pick delay FSM; otherwise commit is next-cycle.
module dsky_relay_latch
   import agc_dsky_pkg::*;
#(
   parameter int RELAY_DLY = 20480,
   parameter int CNTW      = 15
)(
   input  logic                  CLOCK,
   input  logic                  rst,
   input  logic                  WCH10_,
   input  logic                  RLYB01,
   input  logic                  RLYB02,
   input  logic                  RLYB03,
   input  logic                  RLYB04,
   input  logic                  RLYB05,
   input  logic                  RLYB06,
   input  logic                  RLYB07,
   input  logic                  RLYB08,
   input  logic                  RLYB09,
   input  logic                  RLYB10,
   input  logic                  RLYB11,
   input  logic                  RYWD12,
   input  logic                  RYWD13,
   input  logic                  RYWD14,
   input  logic                  RYWD16,
   input  logic [3:0]            DSPSEL,
   output logic [NROWS*ROWW-1:0] ROWQ,
   output logic [3:0]            DSPHI,
   output logic [3:0]            DSPLO,
   output logic                  DSPHIBLK,
   output logic                  DSPLOBLK,
   output logic                  DSPFLG,
   output logic                  BUSY,
   output logic                  LOST,
   output logic                  BADADR
);

   logic [ADRW-1:0] adr;
   logic [ROWW-1:0] word;
   logic            wch_hist_reg;
   logic            strobe;
   logic            cap_ok;
   logic            cap_bad;
   logic            load;
   logic            commit;
   logic            badadr_reg;
   pend_t           pend_reg;
   logic [ROWW-1:0] rows_reg [1:NROWS];
   logic [ROWW-1:0] sel_row;

   assign adr  = {RYWD16, RYWD14, RYWD13, RYWD12};
   assign word = {RLYB11, RLYB10, RLYB09, RLYB08, RLYB07, RLYB06,
                  RLYB05, RLYB04, RLYB03, RLYB02, RLYB01};

   // Falling edge of the strobe only, so a held-low strobe captures once.
   assign strobe  = wch_hist_reg & ~WCH10_;
   assign cap_ok  = strobe & adr_ok(adr);
   assign cap_bad = strobe & ~adr_ok(adr);

   always_ff @(posedge CLOCK) begin
      if (rst) begin
         wch_hist_reg <= 1'b1;
         badadr_reg   <= 1'b0;
         pend_reg     <= '0;
      end else begin
         wch_hist_reg <= WCH10_;
         if (cap_bad)
            badadr_reg <= 1'b1;
         if (load)
            pend_reg <= '{adr: adr, word: word};
      end
   end

   always_ff @(posedge CLOCK) begin
      for (int k = 1; k <= NROWS; k++) begin
         if (rst)
            rows_reg[k] <= '0;
         else if (commit && (pend_reg.adr == ADRW'(k)))
            rows_reg[k] <= pend_reg.word;
      end
   end

`ifdef DSKY_RELAY_DELAY_EN
   state_t          state_reg;
   state_t          state_next;
   logic [CNTW-1:0] cnt_reg;
   logic            cnt_zero;
   logic            lost_set;
   logic            lost_reg;

   assign cnt_zero = (cnt_reg == '0);

   always_ff @(posedge CLOCK) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      commit     = 1'b0;
      lost_set   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cap_ok) begin
               load       = 1'b1;
               state_next = PEND;
            end
         end
         PEND: begin
            if (cnt_zero) begin
               // Commit and a fresh capture on the same edge: both are honoured.
               commit = 1'b1;
               if (cap_ok)
                  load = 1'b1;
               else
                  state_next = IDLE;
            end else if (cap_ok) begin
               load     = 1'b1;
               lost_set = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state_reg == PEND);
      LOST = lost_reg;
   end

   always_ff @(posedge CLOCK) begin
      if (rst) begin
         cnt_reg  <= '0;
         lost_reg <= 1'b0;
      end else begin
         if (load)
            cnt_reg <= CNTW'(RELAY_DLY - 1);
         else if ((state_reg == PEND) && !cnt_zero)
            cnt_reg <= cnt_reg - 1'b1;
         if (lost_set)
            lost_reg <= 1'b1;
      end
   end
`else
   logic pend_vld_reg;

   always_ff @(posedge CLOCK) begin
      if (rst)
         pend_vld_reg <= 1'b0;
      else
         pend_vld_reg <= cap_ok;
   end

   assign load   = cap_ok;
   assign commit = pend_vld_reg;
   assign BUSY   = 1'b0;
   assign LOST   = 1'b0;
`endif

   assign BADADR = badadr_reg;

   for (genvar gi = 1; gi <= NROWS; gi++) begin : g_rowq
      assign ROWQ[rowbase(gi) +: ROWW] = rows_reg[gi];
   end

   always_comb begin
      sel_row = '0;
      for (int k = 1; k <= NROWS; k++) begin
         if (DSPSEL == ADRW'(k))
            sel_row = rows_reg[k];
      end
   end

   assign DSPFLG = sel_row[10];

   dsky_relay_decode u_dec_hi (
      .code  (sel_row[9:5]),
      .blk   (DSPHIBLK),
      .digit (DSPHI)
   );

   dsky_relay_decode u_dec_lo (
      .code  (sel_row[4:0]),
      .blk   (DSPLOBLK),
      .digit (DSPLO)
   );

endmodule

// File: tb/tb_dsky_relay_latch.sv
// Directed bench for dsky_relay_latch; expected latency follows DSKY_RELAY_DELAY_EN.
`timescale 1ns/1ps
module tb_dsky_relay_latch;

`ifdef DSKY_RELAY_DELAY_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 1;
`endif

   logic         CLOCK = 1'b0;
   logic         rst = 1'b1;
   logic         WCH10_ = 1'b1;
   logic         RLYB01 = 0, RLYB02 = 0, RLYB03 = 0, RLYB04 = 0, RLYB05 = 0, RLYB06 = 0;
   logic         RLYB07 = 0, RLYB08 = 0, RLYB09 = 0, RLYB10 = 0, RLYB11 = 0;
   logic         RYWD12 = 0, RYWD13 = 0, RYWD14 = 0, RYWD16 = 0;
   logic [3:0]   DSPSEL = 4'd0;
   logic [131:0] ROWQ;
   logic [3:0]   DSPHI, DSPLO;
   logic         DSPHIBLK, DSPLOBLK, DSPFLG, BUSY, LOST, BADADR;

   int errors = 0;
   int checks = 0;

   always #5 CLOCK = ~CLOCK;

   dsky_relay_latch #(.RELAY_DLY(4), .CNTW(15)) u_dut (
      .CLOCK(CLOCK), .rst(rst), .WCH10_(WCH10_),
      .RLYB01(RLYB01), .RLYB02(RLYB02), .RLYB03(RLYB03), .RLYB04(RLYB04),
      .RLYB05(RLYB05), .RLYB06(RLYB06), .RLYB07(RLYB07), .RLYB08(RLYB08),
      .RLYB09(RLYB09), .RLYB10(RLYB10), .RLYB11(RLYB11),
      .RYWD12(RYWD12), .RYWD13(RYWD13), .RYWD14(RYWD14), .RYWD16(RYWD16),
      .DSPSEL(DSPSEL), .ROWQ(ROWQ), .DSPHI(DSPHI), .DSPLO(DSPLO),
      .DSPHIBLK(DSPHIBLK), .DSPLOBLK(DSPLOBLK), .DSPFLG(DSPFLG),
      .BUSY(BUSY), .LOST(LOST), .BADADR(BADADR)
   );

   task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] row(input int k);
      logic [131:0] v;
      v = ROWQ >> (11 * (k - 1));
      return v[10:0];
   endfunction

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic set_in(input logic [3:0] a, input logic [10:0] w);
      {RYWD16, RYWD14, RYWD13, RYWD12} = a;
      {RLYB11, RLYB10, RLYB09, RLYB08, RLYB07, RLYB06,
       RLYB05, RLYB04, RLYB03, RLYB02, RLYB01} = w;
   endtask

   // Strobe low for exactly one edge (the capture edge), then release.
   task automatic wr(input logic [3:0] a, input logic [10:0] w);
      set_in(a, w);
      WCH10_ = 1'b0;
      step();
      WCH10_ = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("reset_rowq", ROWQ, '0);
      chk("reset_busy", BUSY, 1'b0);
      chk("reset_lost", LOST, 1'b0);
      chk("reset_badadr", BADADR, 1'b0);

      // Row 11, digits 2 and 1: row holds until the commit edge.
      wr(4'd11, 11'b0_11001_00011);
      chk("t1_row11_t0", row(11), '0);
      chk("t1_busy_t0", BUSY, (LAT > 1));
      for (int i = 1; i < LAT; i++) begin
         step();
         chk($sformatf("t1_row11_t%0d", i), row(11), '0);
         chk($sformatf("t1_busy_t%0d", i), BUSY, 1'b1);
      end
      step();
      chk("t1_row11_commit", row(11), 11'b0_11001_00011);
      chk("t1_busy_after", BUSY, 1'b0);
      DSPSEL = 4'd11;
      #1;
      chk("t1_dsphi", DSPHI, 4'd2);
      chk("t1_dsplo", DSPLO, 4'd1);
      chk("t1_dspflg", DSPFLG, 1'b0);
      chk("t1_hiblk", DSPHIBLK, 1'b0);

`ifdef DSKY_RELAY_DELAY_EN
      // Overwrite while pending: only the second word lands.
      do_reset();
      wr(4'd5, 11'b0_01111_10101);
      step();
      wr(4'd6, 11'b1_11110_11100);
      chk("t2_lost", LOST, 1'b1);
      repeat (3) step();
      chk("t2_row6_early", row(6), '0);
      step();
      chk("t2_row6", row(6), 11'b1_11110_11100);
      chk("t2_row5", row(5), '0);
      chk("t2_busy", BUSY, 1'b0);

      // Second capture exactly on the first commit edge.
      do_reset();
      wr(4'd3, 11'b0_10011_11101);
      repeat (3) step();
      wr(4'd4, 11'b0_11111_11011);
      chk("t3_row3", row(3), 11'b0_10011_11101);
      chk("t3_busy", BUSY, 1'b1);
      repeat (3) step();
      chk("t3_row4_early", row(4), '0);
      step();
      chk("t3_row4", row(4), 11'b0_11111_11011);
      chk("t3_lost", LOST, 1'b0);
      chk("t3_busy_end", BUSY, 1'b0);
`else
      // Immediate commit and back-to-back alternate-cycle writes.
      do_reset();
      wr(4'd9, 11'b0_11100_10011);
      chk("t6_row9_t0", row(9), '0);
      step();
      chk("t6_row9_t1", row(9), 11'b0_11100_10011);
      wr(4'd1, 11'b0_10101_00011);
      step();
      wr(4'd2, 11'b0_11001_11011);
      chk("t6_busy", BUSY, 1'b0);
      step();
      wr(4'd3, 11'b0_01111_11110);
      step();
      wr(4'd4, 11'b1_11100_10011);
      step();
      chk("t6_row1", row(1), 11'b0_10101_00011);
      chk("t6_row2", row(2), 11'b0_11001_11011);
      chk("t6_row3", row(3), 11'b0_01111_11110);
      chk("t6_row4", row(4), 11'b1_11100_10011);
      chk("t6_lost", LOST, 1'b0);
      chk("t6_busy_end", BUSY, 1'b0);
`endif

      // Illegal addresses never capture.
      do_reset();
      wr(4'd0, 11'b0_11111_11111);
      chk("t4_badadr0", BADADR, 1'b1);
      chk("t4_busy0", BUSY, 1'b0);
      do_reset();
      wr(4'd14, 11'b0_11111_11111);
      chk("t4_badadr14", BADADR, 1'b1);
      chk("t4_busy14", BUSY, 1'b0);
      repeat (LAT + 1) step();
      chk("t4_rowq", ROWQ, '0);

      // Strobe held low for 10 cycles: word changes after the first edge.
      set_in(4'd3, 11'b0_00011_00011);
      WCH10_ = 1'b0;
      step();
      set_in(4'd3, 11'b0_11001_11001);
      repeat (9) step();
      WCH10_ = 1'b1;
      repeat (LAT + 1) step();
      chk("t4_hold_row3", row(3), 11'b0_00011_00011);
      chk("t4_hold_lost", LOST, 1'b0);

      // Reset right after a capture discards the pending word.
      do_reset();
      wr(4'd15, 11'b0_11111_11111);
      chk("t5_badadr_set", BADADR, 1'b1);
      wr(4'd7, 11'b0_11011_11011);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_busy", BUSY, 1'b0);
      chk("t5_lost", LOST, 1'b0);
      chk("t5_badadr", BADADR, 1'b0);
      repeat (LAT + 2) step();
      chk("t5_rowq", ROWQ, '0);

      // Blank and illegal codes, flag bit, out-of-range select.
      wr(4'd2, 11'b0_00000_01010);
      repeat (LAT) step();
      wr(4'd12, 11'b1_11111_10101);
      repeat (LAT) step();
      DSPSEL = 4'd2;
      #1;
      chk("dec_hiblk", DSPHIBLK, 1'b1);
      chk("dec_loblk", DSPLOBLK, 1'b0);
      chk("dec_lo_illegal", DSPLO, 4'hF);
      chk("dec_flg2", DSPFLG, 1'b0);
      DSPSEL = 4'd12;
      #1;
      chk("dec_hi9", DSPHI, 4'd9);
      chk("dec_lo0", DSPLO, 4'd0);
      chk("dec_flg12", DSPFLG, 1'b1);
      DSPSEL = 4'd0;
      #1;
      chk("sel0_flg", DSPFLG, 1'b0);
      chk("sel0_hiblk", DSPHIBLK, 1'b1);
      DSPSEL = 4'd13;
      #1;
      chk("sel13_flg", DSPFLG, 1'b0);
      chk("sel13_loblk", DSPLOBLK, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
